controle_bomba_sequencial: RTL
==============================

Name: controle_bomba_sequencial

Overview:
- Sequential pump/valve controller for the water-flow system.
- Computes raw demand from four level sensors a..d: demand = a & b & (c | d). This is the same function as the combinational flow-control output.
- Debounces that demand, then sequences valve opening, pump run and valve closing with enforced minimum on/off times and a maximum-run fault lockout.
- Drives the physical valve and pump enables and an alarm lamp.

Parameters:
- DEB, 4: consecutive cycles the raw demand must hold a new value before the filtered demand changes (≥1).
- VALVE_DLY, 8: cycles the valve stays open with the pump off, both before pump start and after pump stop (≥1).
- MIN_ON, 16: minimum pump-on cycles (≥1).
- MAX_ON, 200: pump-on cycle count that triggers a fault (MAX_ON > MIN_ON).
- MIN_OFF, 16: cycles both valve and pump stay off after a stop (≥1).
- CNT_W, 8: state-timer width; must hold max(VALVE_DLY, MAX_ON, MIN_OFF) - 1.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- a, b, c, d  in  1 each  level sensors (raw, may glitch)
- ack  in  1  operator fault acknowledge
- valvula  out  1  valve enable
- bomba  out  1  pump enable
- alarme  out  1  fault indicator
- demanda_f  out  1  debounced demand
- estado  out  3  current FSM state encoding

Behaviour:
- Reset: one clock; reset is synchronous and active-low.
  - On a rising clk edge with rst_n=0: state=OCIOSO; valvula, bomba, alarme, demanda_f = 0; timers and debounce counter = 0.
  - Reset takes priority over everything, including mid-sequence (pump drops on the same edge).
- Debounce:
  - raw = a&b&(c|d), evaluated combinationally each cycle.
  - demanda_f toggles to v on the DEB-th consecutive rising edge at which raw==v and demanda_f!=v.
  - Any edge with raw==demanda_f clears the counter.
  - Result: a step on raw appears on demanda_f DEB edges later; pulses shorter than DEB cycles are ignored.
- State encoding (estado): OCIOSO=0, ABRE=1, BOMBA=2, PARA=3, ESPERA=4, FALHA=5. Codes 6 and 7 go to OCIOSO on the next edge.
- Timer t: cleared to 0 on every state entry, incremented each cycle in state, saturating at all-ones. "N cycles in state" means the transition fires on the edge where t==N-1.
- Outputs are registered, decoded from state:
  - valvula=1 in ABRE, BOMBA, PARA.
  - bomba=1 only in BOMBA.
  - alarme=1 only in FALHA.
- Transitions:
  - OCIOSO: demanda_f=1 → ABRE.
  - ABRE: demanda_f=0 → OCIOSO (pump never ran, so no MIN_OFF). Otherwise after VALVE_DLY cycles → BOMBA.
  - BOMBA:
    - t==MAX_ON-1 → FALHA. This has priority over a normal stop.
    - Otherwise demanda_f=0 and t≥MIN_ON-1 → PARA.
    - A demand drop before MIN_ON is held: the pump keeps running and stops once the minimum is reached if demand is still low.
  - PARA: after VALVE_DLY cycles → ESPERA. Demand is ignored.
  - ESPERA: after MIN_OFF cycles → OCIOSO. Demand is ignored; a pending demand restarts from OCIOSO on the next edge.
  - FALHA: ack=1 and demanda_f=0 on the same edge → OCIOSO. ack while demanda_f=1 is ignored. FALHA is held indefinitely otherwise.
- Outputs never glitch; the valve is always open whenever the pump is on.

Decomposition:
- Package pkg_controle_agua holds:
  - state enum/localparams (OCIOSO..FALHA, 3 bits);
  - default timing constants;
  - demand function as a shared function so the combinational block and this block stay consistent.
- Sub-module filtro_demanda (raw in, demanda_f out, parameter DEB; clk/rst_n) is the natural split.
- Top module: FSM + timer.

Test Plan:
- Reset with a=b=c=1 for 3 cycles, rst_n=0 → all outputs 0 and estado=0 throughout; debounce restarts after release.
- Set a=b=c=1 at edge 0 and hold:
  - demanda_f=1 at edge 4;
  - valvula=1, estado=1 at edge 5;
  - bomba=1 at edge 13.
  - Then drop c at bomba+30 cycles → bomba=0 at +4+1 edges, valvula=0 8 cycles later, estado=0 after 16 more.
- Glitch: a=b=1, c pulses high for 3 cycles → demanda_f, valvula, bomba stay 0.
- Min-on: demand removed 2 cycles after bomba rises → bomba stays high exactly 16 cycles total, then PARA.
- Max-on: hold demand → bomba=0 and alarme=1 after 200 cycles in BOMBA.
  - ack with demand high → remains FALHA.
  - Drop demand, wait 4 cycles, pulse ack → estado=0, alarme=0 next edge.
- Reset mid-run: rst_n=0 for one edge while estado=2 → bomba=0, valvula=0 on that edge; an illegal estado forced via bench reaches OCIOSO in 1 cycle.

Source files
------------

// File: rtl/controle_bomba_sequencial_pkg.sv
// Shared definitions for the water-flow pump/valve control blocks.
package pkg_controle_agua;

  // Controller states. Codes 6 and 7 are unused and fall back to OCIOSO.
  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    ABRE   = 3'd1,
    BOMBA  = 3'd2,
    PARA   = 3'd3,
    ESPERA = 3'd4,
    FALHA  = 3'd5
  } estado_e;

  // Default timing, in clock cycles.
  localparam int DEB_DEF       = 4;
  localparam int VALVE_DLY_DEF = 8;
  localparam int MIN_ON_DEF    = 16;
  localparam int MAX_ON_DEF    = 200;
  localparam int MIN_OFF_DEF   = 16;
  localparam int CNT_W_DEF     = 8;

  // Raw demand from the four level sensors. The combinational flow-control
  // block uses this same function, so both always agree on what "demand" is.
  function automatic logic demanda(input logic a, input logic b,
                                   input logic c, input logic d);
    return a & b & (c | d);
  endfunction

endpackage

// File: rtl/controle_bomba_sequencial_filtro.sv
// Debounce filter: the output follows the raw input only after the input
// has held a new value for DEB consecutive clock edges.
module filtro_demanda #(
  parameter int DEB = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic demanda_f
);

  // Counter only needs to reach DEB-1; keep at least one bit for DEB=1.
  localparam int CW = (DEB > 1) ? $clog2(DEB) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          dem_q, dem_d;

  // Count consecutive disagreeing edges; flip the output on the DEB-th one.
  always_comb begin
    cnt_d = cnt_q;
    dem_d = dem_q;
    if (raw == dem_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      dem_d = raw;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Filter state, synchronously cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dem_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dem_q <= dem_d;
    end
  end

  assign demanda_f = dem_q;

endmodule

// File: rtl/controle_bomba_sequencial.sv
// Sequential pump/valve controller: debounced demand opens the valve,
// runs the pump with minimum on/off times, closes the valve and locks
// out into FALHA if the pump runs too long.
module controle_bomba_sequencial
  import pkg_controle_agua::*;
#(
  parameter int DEB       = DEB_DEF,
  parameter int VALVE_DLY = VALVE_DLY_DEF,
  parameter int MIN_ON    = MIN_ON_DEF,
  parameter int MAX_ON    = MAX_ON_DEF,
  parameter int MIN_OFF   = MIN_OFF_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       ack,
  output logic       valvula,
  output logic       bomba,
  output logic       alarme,
  output logic       demanda_f,
  output logic [2:0] estado
);

  // Transition fires on the edge where the timer shows N-1.
  localparam logic [CNT_W-1:0] T_VALVE   = CNT_W'(VALVE_DLY - 1);
  localparam logic [CNT_W-1:0] T_MIN_ON  = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] T_MAX_ON  = CNT_W'(MAX_ON - 1);
  localparam logic [CNT_W-1:0] T_MIN_OFF = CNT_W'(MIN_OFF - 1);

  logic raw;
  logic dem_f;

  estado_e          state_q, state_d;
  logic [CNT_W-1:0] t_q, t_d;
  logic             valv_q, valv_d;
  logic             bomba_q, bomba_d;
  logic             alarme_q, alarme_d;

  assign raw = demanda(a, b, c, d);

  filtro_demanda #(
    .DEB (DEB)
  ) u_filtro (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw       (raw),
    .demanda_f (dem_f)
  );

  // State, timer and decoded outputs all move on the same edge, so the
  // outputs are glitch-free and always match estado.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= OCIOSO;
      t_q      <= '0;
      valv_q   <= 1'b0;
      bomba_q  <= 1'b0;
      alarme_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      valv_q   <= valv_d;
      bomba_q  <= bomba_d;
      alarme_q <= alarme_d;
    end
  end

  // Next state. In BOMBA the max-run fault wins over a normal stop, and a
  // demand drop before the minimum on-time simply waits it out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OCIOSO: if (dem_f) state_d = ABRE;
      ABRE: begin
        if (!dem_f)                state_d = OCIOSO;
        else if (t_q == T_VALVE)   state_d = BOMBA;
      end
      BOMBA: begin
        if (t_q == T_MAX_ON)                 state_d = FALHA;
        else if (!dem_f && t_q >= T_MIN_ON)  state_d = PARA;
      end
      PARA:   if (t_q == T_VALVE)   state_d = ESPERA;
      ESPERA: if (t_q == T_MIN_OFF) state_d = OCIOSO;
      FALHA:  if (ack && !dem_f)    state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
  end

  // Timer restarts on every state change and saturates while held.
  always_comb begin
    t_d = t_q;
    if (state_d != state_q)  t_d = '0;
    else if (t_q != '1)      t_d = t_q + CNT_W'(1);
  end

  // Outputs decoded from the state being entered; valve covers the pump.
  always_comb begin
    valv_d   = 1'b0;
    bomba_d  = 1'b0;
    alarme_d = 1'b0;
    case (state_d)
      ABRE:    valv_d = 1'b1;
      BOMBA: begin
        valv_d  = 1'b1;
        bomba_d = 1'b1;
      end
      PARA:    valv_d = 1'b1;
      FALHA:   alarme_d = 1'b1;
      default: ;
    endcase
  end

  assign valvula   = valv_q;
  assign bomba     = bomba_q;
  assign alarme    = alarme_q;
  assign demanda_f = dem_f;
  assign estado    = state_q;

endmodule
